// File: rtl/irq_controller.sv
// irq_controller: memory-mapped, fixed-priority interrupt controller.
// Rising edges on src are latched as pending and gated by a mask register.
// The lowest pending, unmasked index is presented to the core as irq plus a
// 16-bit handler vector. The core answers with irq_ack, then irq_done.
// Optional macro IRQ_SYNC_EN adds a two-flop synchronizer in front of the
// edge detector on every src bit. This adds two cycles of edge latency.
// Register map (offsets from BASE_ADDR): 0 MASK (RW), 1 PEND (R, W1C),
// 2 STAT (bit7 in service, bits2:0 active index), 3 reads 0.
module irq_controller #(
    parameter int          N_SRC         = 4,
    parameter logic [15:0] BASE_ADDR     = 16'hFF10,
    parameter logic [15:0] VECTOR_BASE   = 16'h0004,
    parameter logic [15:0] VECTOR_STRIDE = 16'h0004
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] src,
    input  logic             int_en,
    output logic             irq,
    output logic [15:0]      irq_vector,
    input  logic             irq_ack,
    input  logic             irq_done,
    input  logic [15:0]      addr,
    input  logic [7:0]       din,
    input  logic             w_en,
    input  logic             r_en,
    output logic [7:0]       dout
);

    // All per-source state is kept byte wide. Bits at or above N_SRC are forced to 0.
    localparam logic [7:0] SRC_MASK = 8'((9'd1 << N_SRC) - 9'd1);

    typedef enum logic [1:0] {IDLE, REQ, SERVICE} stateType;

    stateType    state, stateNext;
    logic [7:0]  srcWide;
    logic [7:0]  edgeIn;
    logic [7:0]  srcPrev;
    logic [7:0]  rise;
    logic [7:0]  pending, pendingNext;
    logic [7:0]  mask, maskNext;
    logic [7:0]  eligible;
    logic [7:0]  clrBits;
    logic [2:0]  idx, idxNext;
    logic [2:0]  winner;
    logic        anyEligible;
    logic        irqNext;
    logic [15:0] vectorNext;
    logic        ackClear;
    logic [15:0] offset;
    logic        readHit;
    logic [7:0]  readData;
    logic        writeMask;
    logic        writePend;

    // Widen src to a byte, tying off unused positions.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_src
            if (gi < N_SRC) begin : g_used
                assign srcWide[gi] = src[gi];
            end else begin : g_unused
                assign srcWide[gi] = 1'b0;
            end
        end
    endgenerate

`ifdef IRQ_SYNC_EN
    logic [7:0] syncMeta;
    logic [7:0] syncOut;

    // Two-flop synchronizer per source. Reset clears it so that no stale edges survive.
    always_ff @(posedge clk) begin
        if (rst) begin
            syncMeta <= '0;
            syncOut  <= '0;
        end else begin
            syncMeta <= srcWide;
            syncOut  <= syncMeta;
        end
    end

    assign edgeIn = syncOut;
`else
    assign edgeIn = srcWide;
`endif

    assign rise     = edgeIn & ~srcPrev;
    assign eligible = pending & mask;
    assign anyEligible = |eligible;

    assign offset    = addr - BASE_ADDR;
    assign readHit   = (offset < 16'd4);
    assign writeMask = w_en && (offset == 16'd0);
    assign writePend = w_en && (offset == 16'd1);

    // Fixed priority: the lowest eligible index wins (scan downwards, last hit sticks).
    always_comb begin
        winner = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (eligible[i]) begin
                winner = 3'(i);
            end
        end
    end

    // Register read mux. STAT only reports an index while a request is live.
    always_comb begin
        readData = 8'h00;
        case (offset)
            16'd0:   readData = mask;
            16'd1:   readData = pending;
            16'd2:   readData = {(state == SERVICE), 4'b0000,
                                 ((state != IDLE) ? idx : 3'd0)};
            default: readData = 8'h00;
        endcase
    end

    // Arbitration and handshake FSM. Outputs are computed as next-register values.
    always_comb begin
        stateNext  = state;
        idxNext    = idx;
        irqNext    = irq;
        vectorNext = irq_vector;
        ackClear   = 1'b0;
        case (state)
            IDLE: begin
                if (int_en && anyEligible) begin
                    stateNext  = REQ;
                    idxNext    = winner;
                    irqNext    = 1'b1;
                    vectorNext = VECTOR_BASE + VECTOR_STRIDE * {13'd0, winner};
                end
            end
            REQ: begin
                if (irq_ack) begin
                    stateNext = SERVICE;
                    irqNext   = 1'b0;
                    ackClear  = 1'b1;
                end else if (!int_en || !eligible[idx]) begin
                    stateNext = IDLE;
                    irqNext   = 1'b0;
                end
            end
            SERVICE: begin
                irqNext = 1'b0;
                if (irq_done) begin
                    stateNext = IDLE;
                end
            end
            default: begin
                stateNext = IDLE;
                irqNext   = 1'b0;
            end
        endcase
    end

    // Pending bits: clears (W1C, ack) first, then new edges. A new edge wins over a clear.
    // A mask write only takes effect next cycle, so this cycle's arbitration uses the old mask.
    always_comb begin
        clrBits = (writePend ? din : 8'h00) | (ackClear ? (8'b1 << idx) : 8'h00);
        pendingNext = ((pending & ~clrBits) | rise) & SRC_MASK;
        maskNext    = writeMask ? (din & SRC_MASK) : mask;
    end

    // State register for the FSM, pending/mask, edge history and the registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= 3'd0;
            irq        <= 1'b0;
            irq_vector <= VECTOR_BASE;
            pending    <= '0;
            mask       <= '0;
            srcPrev    <= '0;
            dout       <= 8'h00;
        end else begin
            state      <= stateNext;
            idx        <= idxNext;
            irq        <= irqNext;
            irq_vector <= vectorNext;
            pending    <= pendingNext;
            mask       <= maskNext;
            srcPrev    <= edgeIn;
            if (r_en && readHit) begin
                dout <= readData;
            end
        end
    end

endmodule
